// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, 16x oversampled from an external baud tick.
// Stop-bit errors park in BREAK until the line returns high.
module uart_rx #(
  parameter int NB_DATA    = 8,
  parameter int SB_TICK    = 16,
  parameter int OVERSAMPLE = 16
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_rx,
  output logic               o_rx_done,
  output logic [NB_DATA-1:0] o_data_rx,
  output logic               o_frame_error
);

  localparam int SMAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
  localparam int SW   = (SMAX > 2) ? $clog2(SMAX) : 1;
  localparam int NW   = (NB_DATA > 2) ? $clog2(NB_DATA) : 1;

  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE/2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(NB_DATA - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } state_e;

  state_e              state_q, state_d;
  logic [SW-1:0]       s_q, s_d;
  logic [NW-1:0]       n_q, n_d;
  logic [NB_DATA-1:0]  sh_q, sh_d;
  logic                rx_meta_q, rx_s_q;
  logic                done_q, done_d;
  logic                ferr_q, ferr_d;
  logic [NB_DATA-1:0]  data_q, data_d;

  // State register, synchronizer and registered outputs
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= IDLE;
      s_q       <= '0;
      n_q       <= '0;
      sh_q      <= '0;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      sh_q      <= sh_d;
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
      data_q    <= data_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    sh_d    = sh_q;
    unique case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (i_tick) begin
          if (s_q == S_MID) begin
            s_d = '0;
            n_d = '0;
            state_d = rx_s_q ? IDLE : DATA;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      DATA: begin
        if (i_tick) begin
          if (s_q == S_BIT) begin
            s_d  = '0;
            sh_d = {rx_s_q, sh_q[NB_DATA-1:1]};
            if (n_q == N_LAST) begin
              state_d = STOP;
              n_d     = '0;
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      STOP: begin
        if (i_tick) begin
          if (s_q == S_STOP) begin
            s_d     = '0;
            state_d = rx_s_q ? IDLE : BRK;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      BRK: begin
        s_d = '0;
        n_d = '0;
        if (rx_s_q) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        s_d     = '0;
        n_d     = '0;
      end
    endcase
  end

  // Output logic: pulses only on the stop-bit sample cycle
  always_comb begin
    done_d = 1'b0;
    ferr_d = 1'b0;
    data_d = data_q;
    if (state_q == STOP && i_tick && s_q == S_STOP) begin
      if (rx_s_q) begin
        done_d = 1'b1;
        data_d = sh_q;
      end else begin
        ferr_d = 1'b1;
      end
    end
  end

  assign o_rx_done     = done_q;
  assign o_frame_error = ferr_q;
  assign o_data_rx     = data_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed scenarios plus random frames against a
// frame-level model (good stop -> byte delivered, bad stop -> one error).
module tb_uart_rx;

  localparam int BITC = 64;

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_tick = 1'b0;
  logic       i_rx = 1'b1;
  logic       o_rx_done;
  logic [7:0] o_data_rx;
  logic       o_frame_error;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int done_cnt = 0;
  int ferr_cnt = 0;
  int done_cyc[$];
  logic [7:0] done_dat[$];

  int exp_done = 0;
  int exp_ferr = 0;
  logic [7:0] exp_data = 8'h00;

  logic prev_done = 1'b0;
  logic prev_ferr = 1'b0;
  logic [7:0] prev_data = 8'h00;

  uart_rx dut (
    .i_clock      (clk),
    .i_reset      (i_reset),
    .i_tick       (i_tick),
    .i_rx         (i_rx),
    .o_rx_done    (o_rx_done),
    .o_data_rx    (o_data_rx),
    .o_frame_error(o_frame_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    forever begin
      repeat (3) @(negedge clk);
      i_tick = 1'b1;
      @(negedge clk);
      i_tick = 1'b0;
    end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!i_reset) begin
      if (o_rx_done) begin
        done_cnt++;
        done_cyc.push_back(cyc);
        done_dat.push_back(o_data_rx);
        chk("done_width", prev_done, 0);
        chk("done_ferr_excl", o_frame_error, 0);
      end
      if (o_frame_error) begin
        ferr_cnt++;
        chk("ferr_width", prev_ferr, 0);
      end
      if (o_data_rx !== prev_data)
        chk("data_stable", o_rx_done, 1);
    end
    prev_done = o_rx_done;
    prev_ferr = o_frame_error;
    prev_data = o_data_rx;
  end

  task automatic hold(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(logic [7:0] b, logic stop_ok);
    i_rx = 1'b0;
    hold(BITC);
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      hold(BITC);
    end
    i_rx = stop_ok;
    hold(BITC);
    i_rx = 1'b1;
    if (stop_ok) begin
      exp_done++;
      exp_data = b;
    end else begin
      exp_ferr++;
    end
  endtask

  task automatic compare(string tag);
    chk({tag, "_done"}, done_cnt, exp_done);
    chk({tag, "_ferr"}, ferr_cnt, exp_ferr);
    chk({tag, "_data"}, o_data_rx, exp_data);
  endtask

  initial begin
    logic [7:0] b;
    logic ok;
    int gap;

    hold(5);
    chk("rst_done", o_rx_done, 0);
    chk("rst_ferr", o_frame_error, 0);
    chk("rst_data", o_data_rx, 0);
    i_reset = 1'b0;
    hold(100);

    send(8'hA5, 1'b1);
    hold(100);
    compare("t1");

    i_rx = 1'b0;
    hold(12);
    i_rx = 1'b1;
    hold(200);
    compare("t2");

    send(8'h3C, 1'b0);
    hold(100);
    compare("t3a");
    send(8'h11, 1'b1);
    hold(100);
    compare("t3b");

    done_cyc.delete();
    done_dat.delete();
    send(8'hFF, 1'b1);
    send(8'hFF, 1'b1);
    hold(100);
    compare("t4");
    chk("t4_pulses", done_cyc.size(), 2);
    if (done_cyc.size() == 2) begin
      chk("t4_spacing", done_cyc[1] - done_cyc[0], 640);
      chk("t4_code0", done_dat[0], 8'hFF);
      chk("t4_code1", done_dat[1], 8'hFF);
    end

    b = 8'h5A;
    i_rx = 1'b0;
    hold(BITC);
    for (int i = 0; i < 4; i++) begin
      i_rx = b[i];
      hold(BITC);
    end
    i_rx = b[4];
    hold(BITC / 2);
    i_reset = 1'b1;
    #1;
    chk("t5_rst_data", o_data_rx, 0);
    chk("t5_rst_done", o_rx_done, 0);
    chk("t5_rst_ferr", o_frame_error, 0);
    exp_data = 8'h00;
    i_rx = 1'b1;
    hold(20);
    i_reset = 1'b0;
    hold(200);
    compare("t5a");
    send(8'hC3, 1'b1);
    hold(100);
    compare("t5b");

    i_rx = 1'b0;
    hold(30 * BITC);
    exp_ferr++;
    compare("t6_low");
    i_rx = 1'b1;
    hold(200);
    compare("t6_high");

    for (int k = 0; k < 10; k++) begin
      b = 8'($urandom);
      ok = ($urandom_range(3) != 0);
      send(b, ok);
      gap = ok ? $urandom_range(2) * BITC : BITC;
      hold(gap);
    end
    hold(100);
    compare("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
